// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer control / interrupt stage.
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StRun  = 2'd2
    } state_e;

    localparam int unsigned NDefault     = 32;
    localparam int unsigned MissWDefault = 8;

endpackage

// File: rtl/irq_pend.sv
// Interrupt pending latch with req/ack handshake and a saturating overrun counter.
module irq_pend #(
    parameter int unsigned MissW = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             end_i,
    input  logic             ack_i,
    output logic             req_o,
    output logic [MissW-1:0] miss_cnt_o
);

    logic             req_q, req_d;
    logic [MissW-1:0] miss_q, miss_d;

    always_comb begin
        req_d  = req_q;
        miss_d = miss_q;
        // A new end beats a same-cycle ack, so the request stays up.
        if (end_i) begin
            req_d = 1'b1;
        end else if (ack_i) begin
            req_d = 1'b0;
        end
        if (end_i && req_q && !ack_i && (miss_q != '1)) begin
            miss_d = miss_q + MissW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            req_q  <= 1'b0;
            miss_q <= '0;
        end else begin
            req_q  <= req_d;
            miss_q <= miss_d;
        end
    end

    assign req_o      = req_q;
    assign miss_cnt_o = miss_q;

endmodule

// File: rtl/timer_irq_ctrl.sv
// Control FSM around the tick timer: arms/reloads it, runs it one-shot or periodic,
// and hands end-of-period events to the interrupt pending latch.
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned N      = NDefault,
    parameter int unsigned MISS_W = MissWDefault
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Pwr_off,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Periodic,
    input  logic [N-1:0]      Period,
    input  logic              Tmr_end,
    output logic              Tmr_en,
    output logic [N-1:0]      Tmr_load,
    output logic              Tmr_rst,
    output logic              Irq_req,
    input  logic              Irq_ack,
    output logic              Busy,
    output logic [MISS_W-1:0] Miss_cnt
);

    state_e         state_q, state_d;
    logic [N-1:0]   period_q, period_d;
    logic           mode_q, mode_d;
    logic           clr;
    logic           start_ok;
    logic           end_ok;

    assign clr      = Rst | Pwr_off;
    assign start_ok = Start && (Period != '0);
    assign end_ok   = Tmr_end && (state_q == StRun);

    always_ff @(posedge Clk) begin
        if (clr) begin
            state_q  <= StIdle;
            period_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        mode_d   = mode_q;
        if (Stop) begin
            state_d = StIdle;
        end else if (start_ok) begin
            // Start from any state (re)arms with freshly sampled period and mode.
            state_d  = StArm;
            period_d = Period;
            mode_d   = Periodic;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StIdle;
                StArm:   state_d = StRun;
                StRun:   if (Tmr_end && !mode_q) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        Tmr_en  = (state_q == StRun);
        Tmr_rst = (state_q == StArm);
        Busy    = (state_q == StArm) || (state_q == StRun);
    end

    assign Tmr_load = period_q - N'(1);

    irq_pend #(
        .MissW (MISS_W)
    ) u_irq_pend (
        .clk_i      (Clk),
        .clr_i      (clr),
        .end_i      (end_ok),
        .ack_i      (Irq_ack),
        .req_o      (Irq_req),
        .miss_cnt_o (Miss_cnt)
    );

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl with a behavioural tick timer in the loop.
module tb_timer_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst, pwr_off, start, stop, periodic, irq_ack, end_inj;
    logic [31:0] period;
    logic        tmr_end;
    logic        tmr_en, tmr_rst, irq_req, busy;
    logic [31:0] tmr_load;
    logic [7:0]  miss_cnt;
    logic        tmr_en2, tmr_rst2, irq_req2, busy2;
    logic [31:0] tmr_load2;
    logic [1:0]  miss_cnt2;
    logic [31:0] tcnt = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    timer_irq_ctrl #(.N(32), .MISS_W(8)) dut (
        .Clk(clk), .Rst(rst), .Pwr_off(pwr_off), .Start(start), .Stop(stop),
        .Periodic(periodic), .Period(period), .Tmr_end(tmr_end), .Tmr_en(tmr_en),
        .Tmr_load(tmr_load), .Tmr_rst(tmr_rst), .Irq_req(irq_req), .Irq_ack(irq_ack),
        .Busy(busy), .Miss_cnt(miss_cnt)
    );

    timer_irq_ctrl #(.N(32), .MISS_W(2)) dut2 (
        .Clk(clk), .Rst(rst), .Pwr_off(pwr_off), .Start(start), .Stop(stop),
        .Periodic(periodic), .Period(period), .Tmr_end(tmr_end), .Tmr_en(tmr_en2),
        .Tmr_load(tmr_load2), .Tmr_rst(tmr_rst2), .Irq_req(irq_req2), .Irq_ack(irq_ack),
        .Busy(busy2), .Miss_cnt(miss_cnt2)
    );

    // Tick timer: reload on strobe, count down while enabled, end pulse at zero.
    always_ff @(posedge clk) begin
        if (tmr_rst) tcnt <= tmr_load;
        else if (tmr_en) tcnt <= (tcnt == 0) ? tmr_load : tcnt - 1;
    end
    assign tmr_end = (tmr_en && tcnt == 0) || end_inj;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_irq"}, irq_req, 0);
        chk({tag, "_miss"}, miss_cnt, 0);
        chk({tag, "_en"}, tmr_en, 0);
        chk({tag, "_rst"}, tmr_rst, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_load"}, tmr_load, 32'hFFFF_FFFF);
    endtask

    initial begin
        rst = 1; pwr_off = 0; start = 1; stop = 0; periodic = 1; irq_ack = 0;
        end_inj = 0; period = 5;
        tick(); tick();
        chk_reset("reset");
        rst = 0; start = 0;
        tick();
        chk("reset_idle_busy", busy, 0);

        // One-shot, Period=5
        start = 1; period = 5; periodic = 0;
        tick(); start = 0;
        chk("os_arm_rst", tmr_rst, 1);
        chk("os_arm_load", tmr_load, 4);
        chk("os_arm_en", tmr_en, 0);
        chk("os_arm_busy", busy, 1);
        tick();
        chk("os_run_en", tmr_en, 1);
        repeat (4) tick();
        chk("os_end5", tmr_end, 1);
        chk("os_irq_before", irq_req, 0);
        tick();
        chk("os_irq", irq_req, 1);
        chk("os_idle_busy", busy, 0);
        chk("os_idle_en", tmr_en, 0);
        irq_ack = 1; tick(); irq_ack = 0;
        chk("os_ack", irq_req, 0);

        // Periodic Period=3, no ack, 20 periods
        start = 1; period = 3; periodic = 1;
        tick(); start = 0;
        chk("per_load", tmr_load, 2);
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick(); tick();
            chk("per_end", tmr_end, 1);
            tick();
            chk("per_irq", irq_req, 1);
            chk("per_miss", miss_cnt, k - 1);
            chk("per_miss_sat", miss_cnt2, (k - 1 > 3) ? 3 : k - 1);
        end

        // Same-cycle end and ack
        tick(); tick();
        chk("sc_end", tmr_end, 1);
        irq_ack = 1; tick(); irq_ack = 0;
        chk("sc_irq", irq_req, 1);
        chk("sc_miss", miss_cnt, 19);
        // Ack mid-period, next end is not a miss
        irq_ack = 1; tick(); irq_ack = 0;
        chk("mid_ack", irq_req, 0);
        tick(); tick();
        chk("mid_irq", irq_req, 1);
        chk("mid_miss", miss_cnt, 19);

        // Stop mid-run keeps the request
        stop = 1; tick(); stop = 0;
        chk("stop_busy", busy, 0);
        chk("stop_en", tmr_en, 0);
        chk("stop_irq", irq_req, 1);

        // Stop beats Start
        start = 1; stop = 1; period = 4; tick(); start = 0; stop = 0;
        chk("ss_busy", busy, 0);
        chk("ss_load", tmr_load, 2);

        // Restart in RUN with Period=7 one-shot
        start = 1; period = 3; periodic = 1; tick(); start = 0;
        tick();
        chk("rs_run", tmr_en, 1);
        start = 1; period = 7; periodic = 0; tick(); start = 0;
        chk("rs_arm_rst", tmr_rst, 1);
        chk("rs_arm_load", tmr_load, 6);
        tick();
        repeat (6) tick();
        chk("rs_end7", tmr_end, 1);
        tick();
        chk("rs_idle", busy, 0);
        chk("rs_miss", miss_cnt, 20);
        chk("rs_miss_sat", miss_cnt2, 3);
        irq_ack = 1; tick(); irq_ack = 0;
        chk("rs_ack", irq_req, 0);

        // Period=0 start is ignored
        start = 1; period = 0; tick(); start = 0;
        chk("p0_busy", busy, 0);
        chk("p0_load", tmr_load, 6);

        // End outside RUN is ignored
        end_inj = 1; tick(); end_inj = 0;
        chk("idle_end_irq", irq_req, 0);
        chk("idle_end_miss", miss_cnt, 20);

        // Period=1 periodic: end every RUN cycle
        start = 1; period = 1; periodic = 1; tick(); start = 0;
        chk("p1_load", tmr_load, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("p1_end", tmr_end, 1);
            tick();
            chk("p1_irq", irq_req, 1);
            chk("p1_miss", miss_cnt, 20 + k);
        end

        // Power-off mid-run clears everything
        pwr_off = 1; tick(); pwr_off = 0;
        chk_reset("pwroff");
        chk("pwroff_miss2", miss_cnt2, 0);
        tick();
        chk("pwroff_after_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
